// File: rtl/evt_burst_gen.sv
// Programmable event-burst generator: on start, emits N single-cycle strobes
// spaced P cycles apart, then pulses done_out. All outputs are registered.
module evt_burst_gen #(
  parameter  int MAX_COUNT  = 1024,
  parameter  int MAX_PERIOD = 65535,
  localparam int CW         = $clog2(MAX_COUNT + 1),
  localparam int PW         = $clog2(MAX_PERIOD + 1)
) (
  input  logic          clk_in,
  input  logic          rst_n_in,
  input  logic          start_in,
  input  logic [CW-1:0] count_in,
  input  logic [PW-1:0] period_in,
  input  logic          abort_in,
  output logic          evt_out,
  output logic [CW-1:0] evt_index_out,
  output logic          busy_out,
  output logic          done_out
);

  localparam logic [CW-1:0] MAX_CNT_C = CW'(MAX_COUNT);
  localparam logic [PW-1:0] MAX_PER_C = PW'(MAX_PERIOD);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  function automatic logic [CW-1:0] clamp_count(input logic [CW-1:0] c);
    return (c > MAX_CNT_C) ? MAX_CNT_C : c;
  endfunction

  function automatic logic [PW-1:0] clamp_period(input logic [PW-1:0] p);
    if (p == '0)
      return PW'(1);
    else if (p > MAX_PER_C)
      return MAX_PER_C;
    else
      return p;
  endfunction

  state_t        state, state_nxt;
  logic [CW-1:0] rem;
  logic [PW-1:0] cnt;
  logic [PW-1:0] per;
  logic [CW-1:0] n_eff;
  logic [PW-1:0] p_eff;
  logic          accept;
  logic          strobe_run;
  logic          evt_nxt;
  logic [CW-1:0] idx_nxt;
  logic          busy_nxt;
  logic          done_nxt;

  assign n_eff  = clamp_count(count_in);
  assign p_eff  = clamp_period(period_in);
  // DONE counts as idle so a start on the DONE edge chains bursts back-to-back.
  assign accept = (state != RUN) && start_in;
  // abort wins over a strobe falling due on the same edge.
  assign strobe_run = (state == RUN) && !abort_in && (rem != '0) && (cnt == '0);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE, DONE: begin
        if (accept)
          state_nxt = (n_eff == '0) ? DONE : RUN;
        else
          state_nxt = IDLE;
      end
      RUN: begin
        if (abort_in)
          state_nxt = IDLE;
        else if (rem == '0)
          state_nxt = DONE;
        else
          state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    evt_nxt  = 1'b0;
    idx_nxt  = evt_index_out;
    busy_nxt = (state_nxt == RUN);
    done_nxt = (state_nxt == DONE);
    if (accept && (n_eff != '0)) begin
      evt_nxt = 1'b1;
      idx_nxt = '0;
    end else if (strobe_run) begin
      evt_nxt = 1'b1;
      idx_nxt = evt_index_out + CW'(1);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      evt_out       <= 1'b0;
      evt_index_out <= '0;
      busy_out      <= 1'b0;
      done_out      <= 1'b0;
    end else begin
      evt_out       <= evt_nxt;
      evt_index_out <= idx_nxt;
      busy_out      <= busy_nxt;
      done_out      <= done_nxt;
    end
  end

  // rem = strobes still to come after the current one; cnt = cycles to next strobe.
  always_ff @(posedge clk_in) begin
    if (accept && (n_eff != '0)) begin
      rem <= n_eff - CW'(1);
      cnt <= p_eff - PW'(1);
      per <= p_eff;
    end else if (strobe_run) begin
      rem <= rem - CW'(1);
      cnt <= per - PW'(1);
    end else if ((state == RUN) && (cnt != '0)) begin
      cnt <= cnt - PW'(1);
    end
  end

endmodule
